// File: rtl/lc_trans_pkg.sv
// Shared life cycle transition types: decoded state codes, status codes, legality table.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lc_trans_pkg;

    localparam int DecLcStateWidth  = 3;
    localparam int DecLcStateNumRep = 2;

    // Codes 4..7 are all treated as Invalid; only 4 is named.
    typedef enum logic [DecLcStateWidth-1:0] {
        DecLcStRaw           = 3'd0,
        DecLcStTestUnlocked0 = 3'd1,
        DecLcStTestLocked0   = 3'd2,
        DecLcStRma           = 3'd3,
        DecLcStInvalid       = 3'd4
    } dec_lc_state_e;

    typedef enum logic [1:0] {
        TransStOk          = 2'd0,
        TransStLocalReject = 2'd1,
        TransStCtrlError   = 2'd2,
        TransStTimeout     = 2'd3
    } trans_status_e;

    // Legal transitions: Raw->TU0, TU0->TL0, TL0->TU0, TU0->Rma, TL0->Rma.
    // Anything involving an Invalid code, leaving Rma, or target==current is illegal.
    function automatic logic is_legal_trans(input logic [DecLcStateWidth-1:0] cur,
                                            input logic [DecLcStateWidth-1:0] tgt);
        logic legal;
        legal = 1'b0;
        case (cur)
            DecLcStRaw:           legal = (tgt == DecLcStTestUnlocked0);
            DecLcStTestUnlocked0: legal = (tgt == DecLcStTestLocked0) || (tgt == DecLcStRma);
            DecLcStTestLocked0:   legal = (tgt == DecLcStTestUnlocked0) || (tgt == DecLcStRma);
            default:              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lc_trans_timeout_cnt.sv
// Saturating wait-cycle counter: start/clear reload zero, en counts, expired flags the last allowed cycle.
// Latency: expired asserts combinationally during the Limit-th enabled cycle after start.
// Backpressure: none; counter holds at Limit and never wraps.
module lc_trans_timeout_cnt #(
    parameter int Limit = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_start,
    input  logic i_en,
    output logic o_expired
);

    localparam int CntW = $clog2(Limit + 1);

    logic [CntW-1:0] r_cnt;

    // Count enabled cycles since the last start, saturating at Limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || i_start) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CntW'(Limit))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the number of earlier enabled cycles, so Limit-1 marks the Limit-th one
    assign o_expired = (r_cnt >= CntW'(Limit - 1));

endmodule

// File: rtl/lc_trans_requester.sv
// Host-side LC transition requester: screens, issues trans_cmd, waits/retries, returns one status.
// Latency: cmd 2 cycles after accept; local reject status at 2, fastest success status at 3.
// Backpressure: req_ready_o only in IDLE; status held until resp_ready_i. LC_TRANS_REQ_HIST_EN enables trans_hist_o.
module lc_trans_requester
    import lc_trans_pkg::*;
#(
    parameter int NumRep        = DecLcStateNumRep,
    parameter int TimeoutCycles = 64,
    parameter int MaxRetries    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_target_i,
    input  logic [2:0]            lc_state_i,
    output logic                  trans_cmd_o,
    output logic [3*NumRep-1:0]   trans_target_o,
    input  logic                  trans_success_i,
    input  logic                  trans_invalid_error_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [1:0]            resp_status_o,
    output logic                  busy_o,
    output logic [11:0]           trans_hist_o
);

    localparam int RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                r_state;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_cmd;
    logic [3*NumRep-1:0]   r_target_rep;
    logic                  r_resp_valid;
    trans_status_e         r_status;
    logic [2:0]            r_tgt;
    logic [2:0]            r_cur;
    logic [RetryW-1:0]     r_retry_cnt;

    logic                  w_legal;
    logic                  w_rsp_any;
    trans_status_e         w_rsp_status;
    logic                  w_can_retry;
    logic                  w_to_expired;
    logic                  w_resp_done;

    assign w_legal      = is_legal_trans(r_cur, r_tgt);
    assign w_rsp_any    = trans_success_i || trans_invalid_error_i;
    // Error wins when both responses arrive together
    assign w_rsp_status = trans_invalid_error_i ? TransStCtrlError : TransStOk;
    assign w_can_retry  = (r_retry_cnt < RetryW'(MaxRetries));
    assign w_resp_done  = (r_state == StResp) && resp_ready_i;

    // Wait window restarts on every ISSUE so each retry gets a full TimeoutCycles
    lc_trans_timeout_cnt #(
        .Limit (TimeoutCycles)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_resp_done),
        .i_start   (r_state == StIssue),
        .i_en      (r_state == StWait),
        .o_expired (w_to_expired)
    );

    // Request FSM with all host/controller-facing outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_cmd        <= 1'b0;
            r_target_rep <= '0;
            r_resp_valid <= 1'b0;
            r_status     <= TransStOk;
            r_tgt        <= '0;
            r_cur        <= '0;
            r_retry_cnt  <= '0;
        end else begin
            r_cmd <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid_i && r_req_ready) begin
                        r_tgt       <= req_target_i;
                        r_cur       <= lc_state_i;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= StCheck;
                    end
                end
                StCheck: begin
                    if (w_legal) begin
                        r_cmd        <= 1'b1;
                        r_target_rep <= {NumRep{r_tgt}};
                        r_state      <= StIssue;
                    end else begin
                        r_status     <= TransStLocalReject;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StIssue, StWait: begin
                    if (w_rsp_any) begin
                        r_status     <= w_rsp_status;
                        r_resp_valid <= 1'b1;
                        r_target_rep <= '0;
                        r_state      <= StResp;
                    end else if ((r_state == StWait) && w_to_expired) begin
                        if (w_can_retry) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_cmd       <= 1'b1;
                            r_state     <= StIssue;
                        end else begin
                            r_status     <= TransStTimeout;
                            r_resp_valid <= 1'b1;
                            r_target_rep <= '0;
                            r_state      <= StResp;
                        end
                    end else begin
                        r_state <= StWait;
                    end
                end
                StResp: begin
                    if (resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                        r_retry_cnt  <= '0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifdef LC_TRANS_REQ_HIST_EN
    logic [11:0] r_hist;
    logic        w_hist_push;

    assign w_hist_push = ((r_state == StIssue) || (r_state == StWait))
                         && trans_success_i && !trans_invalid_error_i;

    // Shift each successfully completed target in, newest in the low bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (w_hist_push) begin
            r_hist <= {r_hist[8:0], r_tgt};
        end
    end

    assign trans_hist_o = r_hist;
`else
    assign trans_hist_o = '0;
`endif

    assign req_ready_o    = r_req_ready;
    assign busy_o         = r_busy;
    assign trans_cmd_o    = r_cmd;
    assign trans_target_o = r_target_rep;
    assign resp_valid_o   = r_resp_valid;
    assign resp_status_o  = r_status;

endmodule

// File: tb/tb_lc_trans_requester.sv
// Scoreboarded bench for lc_trans_requester with a small scripted controller model.
// Latency: checks accept->cmd/status timing directly; status/history via queue monitor.
// Backpressure: host always ready for status; requests issued one at a time.
module tb_lc_trans_requester;

    localparam int NumRep = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [2:0]        req_target_i = '0;
    logic [2:0]        lc_state_i = '0;
    logic              trans_cmd_o;
    logic [3*NumRep-1:0] trans_target_o;
    logic              trans_success_i;
    logic              trans_invalid_error_i;
    logic              resp_valid_o;
    logic              resp_ready_i = 1'b1;
    logic [1:0]        resp_status_o;
    logic              busy_o;
    logic [11:0]       trans_hist_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Controller model: 0 silent, 1 success with cmd, 2 error 3 cycles after cmd, 3 both with cmd
    int ctrl_mode = 0;
    int dly = 0;
    int cmd_cnt = 0;
    logic [2:0] exp_tgt = '0;
    logic [11:0] mdl_hist = '0;

`ifdef LC_TRANS_REQ_HIST_EN
    localparam bit HistOn = 1'b1;
`else
    localparam bit HistOn = 1'b0;
`endif

    typedef struct {
        logic [1:0]  st;
        logic [11:0] hist;
    } exp_t;
    exp_t exp_q[$];

    lc_trans_requester #(
        .NumRep        (NumRep),
        .TimeoutCycles (4),
        .MaxRetries    (2)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_target_i          (req_target_i),
        .lc_state_i            (lc_state_i),
        .trans_cmd_o           (trans_cmd_o),
        .trans_target_o        (trans_target_o),
        .trans_success_i       (trans_success_i),
        .trans_invalid_error_i (trans_invalid_error_i),
        .resp_valid_o          (resp_valid_o),
        .resp_ready_i          (resp_ready_i),
        .resp_status_o         (resp_status_o),
        .busy_o                (busy_o),
        .trans_hist_o          (trans_hist_o)
    );

    always #5 clk = ~clk;

    assign trans_success_i       = ((ctrl_mode == 1) || (ctrl_mode == 3)) && trans_cmd_o;
    assign trans_invalid_error_i = ((ctrl_mode == 3) && trans_cmd_o) || ((ctrl_mode == 2) && (dly == 3));

    always @(posedge clk) begin
        if (trans_cmd_o) dly <= 1;
        else if (dly != 0 && dly < 10) dly <= dly + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: command target and every completed status against the scoreboard
    always @(negedge clk) begin
        if (rst_n && trans_cmd_o) begin
            cmd_cnt++;
            chk("cmd_target", 32'(trans_target_o), 32'({NumRep{exp_tgt}}));
        end
        if (rst_n && resp_valid_o && resp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_status", 32'(resp_status_o), 32'(e.st));
                chk("resp_hist", 32'(trans_hist_o), 32'(e.hist));
            end
        end
    end

    task automatic send(input logic [2:0] cur, input logic [2:0] tgt,
                        input int mode, input logic [1:0] st);
        bit done;
        ctrl_mode = mode;
        exp_tgt   = tgt;
        if (st == 2'd0 && HistOn) mdl_hist = {mdl_hist[8:0], tgt};
        exp_q.push_back('{st: st, hist: mdl_hist});
        @(negedge clk);
        lc_state_i   = cur;
        req_target_i = tgt;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("cyc1_cmd", 32'(trans_cmd_o), 32'd0);
        chk("cyc1_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        if (st == 2'd1) begin
            chk("cyc2_reject_valid", 32'(resp_valid_o), 32'd1);
            chk("cyc2_reject_cmd", 32'(trans_cmd_o), 32'd0);
        end else begin
            chk("cyc2_cmd", 32'(trans_cmd_o), 32'd1);
            chk("cyc2_valid", 32'(resp_valid_o), 32'd0);
        end
        if (mode == 1 || mode == 3) begin
            @(negedge clk);
            chk("cyc3_valid", 32'(resp_valid_o), 32'd1);
        end
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid_o) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk("resp_wait_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("back_idle_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        bit saw;
        #12;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_cmd", 32'(trans_cmd_o), 32'd0);
        chk("rst_target", 32'(trans_target_o), 32'd0);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_status", 32'(resp_status_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_hist", 32'(trans_hist_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(3'd0, 3'd1, 1, 2'd0);   // Raw->TU0, success in ISSUE
        send(3'd0, 3'd3, 0, 2'd1);   // Raw->Rma, illegal
        send(3'd2, 3'd3, 2, 2'd2);   // TL0->Rma, controller error later
        cmd_cnt = 0;
        send(3'd1, 3'd2, 0, 2'd3);   // TU0->TL0, silent controller
        chk("timeout_cmd_pulses", 32'(cmd_cnt), 32'd3);
        send(3'd2, 3'd1, 3, 2'd2);   // both responses together
        send(3'd1, 3'd3, 1, 2'd0);   // TU0->Rma success
        send(3'd5, 3'd1, 0, 2'd1);   // invalid current state
        send(3'd1, 3'd1, 0, 2'd1);   // target equals current
        send(3'd3, 3'd2, 0, 2'd1);   // leaving Rma

        // Reset in the middle of WAIT
        ctrl_mode = 0;
        exp_tgt   = 3'd2;
        @(negedge clk);
        lc_state_i   = 3'd1;
        req_target_i = 3'd2;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cmd", 32'(trans_cmd_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_ready", 32'(req_ready_o), 32'd1);
        chk("midrst_target", 32'(trans_target_o), 32'd0);
        chk("midrst_hist", 32'(trans_hist_o), 32'd0);
        mdl_hist = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid_o) saw = 1'b1;
        end
        chk("post_rst_no_resp", 32'(saw), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc_trans_requester.md
Name: lc_trans_requester

Overview:
Initiator side of the life cycle transition command interface. It accepts one host transition request, screens it against a local legality table, and drives the `trans_cmd`/`trans_target` pair toward the LC controller. It then waits for `trans_success` or `trans_invalid_error`, retrying on timeout, and returns a single status word to the host.

Parameters:
NumRep, 2, number of replicas of the 3-bit target driven on trans_target_o
TimeoutCycles, 64, WAIT cycles with no response before a timeout is declared (min 2)
MaxRetries, 2, re-issues allowed after a timeout before final TIMEOUT status

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  host request valid
req_ready_o  in/out=out  1  high only in IDLE
req_target_i  in  3  requested decoded LC state
lc_state_i  in  3  current decoded LC state from controller
trans_cmd_o  out  1  single-cycle transition command pulse
trans_target_o  out  3*NumRep  replicated target, stable ISSUE..WAIT end
trans_success_i  in  1  controller reports transition accepted
trans_invalid_error_i  in  1  controller reports transition rejected
resp_valid_o  out  1  status valid, held until resp_ready_i
resp_ready_i  in  1  host accepts status
resp_status_o  out  2  0 OK, 1 LOCAL_REJECT, 2 CTRL_ERROR, 3 TIMEOUT
busy_o  out  1  high in every state except IDLE
trans_hist_o  out  12  last four successful targets, newest in [2:0]; see optional feature

Behaviour:
- Encodings: Raw=0, TestUnlocked0=1, TestLocked0=2, Rma=3; values 4..7 are Invalid.
- Reset values: req_ready_o=1, trans_cmd_o=0, trans_target_o=all-Raw, resp_valid_o=0, resp_status_o=0, busy_o=0, trans_hist_o=0.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE: on req_valid_i&&req_ready_o, latch req_target_i and lc_state_i (snapshot), go to CHECK.
- CHECK (1 cycle): the legal set is exactly Raw->TU0, TU0->TL0, TL0->TU0, TU0->Rma, TL0->Rma.
  - Legal pair: go to ISSUE.
  - Anything else (Raw->Rma, from Rma, target==current, any Invalid code): status=1, go to RESP, no trans_cmd_o.
- ISSUE (1 cycle): trans_cmd_o=1, go to WAIT.
  - trans_success_i/trans_invalid_error_i are also sampled in ISSUE, since the controller may answer combinationally.
- WAIT: sample the response each cycle.
  - invalid_error -> status 2 -> RESP. Error has priority if both responses are high in the same cycle.
  - success -> status 0 -> RESP.
  - No response after TimeoutCycles WAIT cycles:
    - retry_cnt<MaxRetries: retry_cnt++, back to ISSUE.
    - Otherwise: status 3 -> RESP.
- RESP: resp_valid_o=1, status stable. On resp_ready_i go to IDLE and clear retry_cnt and the timeout counter.
- Request latency:
  - Legal request: trans_cmd_o is high 2 cycles after acceptance.
  - Rejected request: resp_valid_o is high 2 cycles after acceptance.
  - Fastest success: resp_valid_o is high 3 cycles after acceptance.
- trans_target_o: {NumRep{target}} during ISSUE and WAIT, all-Raw otherwise.
- Responses in IDLE, CHECK and RESP are ignored.
- Timeout counter width is $clog2(TimeoutCycles+1). It saturates and never wraps.
- Reset asserted mid-operation: immediate return to IDLE, trans_cmd_o deasserts asynchronously, no response is emitted, trans_hist_o clears.

Optional Feature:
- Macro LC_TRANS_REQ_HIST_EN.
  - Defined: every status-0 completion shifts the latched target into trans_hist_o (12-bit shift by 3, newest at [2:0]).
  - Undefined: trans_hist_o is tied to 0 and no history flops are inferred.

Decomposition:
- Package lc_trans_pkg:
  - dec_lc_state_e (3-bit enum above)
  - trans_status_e (2-bit)
  - DecLcStateNumRep constant
  - function is_legal_trans(cur, tgt), shared with the controller model
- Sub-module lc_trans_timeout_cnt: loadable saturating counter with clear, start and expired outputs.

Test Plan:
- Idle lc_state_i=Raw, request TU0, controller asserts success in the ISSUE cycle -> trans_cmd_o pulse at cycle 2, trans_target_o=6'b001_001, resp_status_o=0 at cycle 3, trans_hist_o[2:0]=1 with macro.
- lc_state_i=Raw, request Rma -> no trans_cmd_o, resp_status_o=1 two cycles after acceptance.
- lc_state_i=TL0, request Rma, controller asserts invalid_error 3 cycles after cmd -> resp_status_o=2, trans_hist_o unchanged.
- TimeoutCycles=4, MaxRetries=2, controller silent -> exactly 3 trans_cmd_o pulses, then resp_status_o=3.
- success and invalid_error high in the same cycle -> resp_status_o=2.
- rst_n dropped during WAIT -> trans_cmd_o=0, busy_o=0, req_ready_o=1 immediately, no resp_valid_o after release.
